// File: rtl/bp_fe_cmd_scheduler.sv
// FE command scheduler: control and attaboy FIFOs feeding one valid/yumi port, control first, bounded attaboy starvation.
// Define BP_FE_SCHED_ATTABOY_FLUSH_EN to also flush queued attaboys when a PC redirect is dequeued.

module bp_fe_cmd_fifo #(
  parameter int width_p = 32,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int ptr_w = $clog2(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rptr_r, wptr_r;
  logic               rwrap_r, wwrap_r;

  assign full_o  = (rptr_r == wptr_r) && (rwrap_r != wwrap_r);
  assign empty_o = (rptr_r == wptr_r) && (rwrap_r == wwrap_r);
  assign data_o  = mem[rptr_r];

  // clear wins over a same-cycle enqueue, which is dropped
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      rwrap_r <= 1'b0;
      wwrap_r <= 1'b0;
    end else if (clear_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      rwrap_r <= 1'b0;
      wwrap_r <= 1'b0;
    end else begin
      if (enq_i) begin
        if (wptr_r == ptr_w'(els_p - 1)) begin
          wptr_r  <= '0;
          wwrap_r <= ~wwrap_r;
        end else begin
          wptr_r <= wptr_r + ptr_w'(1);
        end
      end
      if (deq_i) begin
        if (rptr_r == ptr_w'(els_p - 1)) begin
          rptr_r  <= '0;
          rwrap_r <= ~rwrap_r;
        end else begin
          rptr_r <= rptr_r + ptr_w'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i) mem[wptr_r] <= data_i;
  end
endmodule

// Command width is given directly; the opcode occupies the low 4 bits of a command.
module bp_fe_cmd_scheduler #(
  parameter int fe_cmd_width_p   = 32,
  parameter int ctrl_els_p       = 4,
  parameter int attaboy_els_p    = 8,
  parameter int attaboy_starve_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [fe_cmd_width_p-1:0] ctrl_cmd_i,
  input  logic                      ctrl_v_i,
  output logic                      ctrl_ready_and_o,
  input  logic [fe_cmd_width_p-1:0] attaboy_cmd_i,
  input  logic                      attaboy_v_i,
  output logic                      attaboy_ready_and_o,
  output logic [fe_cmd_width_p-1:0] fe_cmd_o,
  output logic                      fe_cmd_v_o,
  input  logic                      fe_cmd_yumi_i,
  output logic                      ctrl_empty_o
);
  localparam logic [3:0] e_op_state_reset    = 4'd0;
  localparam logic [3:0] e_op_pc_redirection = 4'd1;
  localparam int starve_w = (attaboy_starve_p == 0) ? 1 : $clog2(attaboy_starve_p + 1);
  localparam logic [starve_w-1:0] starve_max = starve_w'(attaboy_starve_p);

  logic [fe_cmd_width_p-1:0] ctrl_data, atb_data;
  logic ctrl_full, ctrl_empty, atb_full, atb_empty;
  logic ctrl_enq, atb_enq, ctrl_deq, atb_deq, atb_flush;
  logic starve_hit, sel_fresh, sel_attaboy;
  logic [starve_w-1:0] starve_r;
  logic hold_r, sel_attaboy_r;

  assign ctrl_ready_and_o    = reset_n_i & ~ctrl_full;
  assign attaboy_ready_and_o = reset_n_i & ~atb_full;
  assign ctrl_enq            = ctrl_v_i & ctrl_ready_and_o;
  assign atb_enq             = attaboy_v_i & attaboy_ready_and_o;
  assign ctrl_empty_o        = ctrl_empty;

  // a command left waiting (valid, no yumi) keeps its queue selected next cycle
  assign starve_hit  = (attaboy_starve_p != 0) && (starve_r == starve_max);
  assign sel_fresh   = ~atb_empty & (ctrl_empty | starve_hit);
  assign sel_attaboy = hold_r ? sel_attaboy_r : sel_fresh;

  assign fe_cmd_v_o = ~ctrl_empty | ~atb_empty;
  assign fe_cmd_o   = sel_attaboy ? atb_data : ctrl_data;

  assign ctrl_deq = fe_cmd_yumi_i & ~sel_attaboy & ~ctrl_empty;
  assign atb_deq  = fe_cmd_yumi_i &  sel_attaboy & ~atb_empty;

`ifdef BP_FE_SCHED_ATTABOY_FLUSH_EN
  assign atb_flush = ctrl_deq & ((ctrl_data[3:0] == e_op_state_reset)
                               | (ctrl_data[3:0] == e_op_pc_redirection));
`else
  assign atb_flush = ctrl_deq & (ctrl_data[3:0] == e_op_state_reset);
`endif

  bp_fe_cmd_fifo #(.width_p(fe_cmd_width_p), .els_p(ctrl_els_p)) ctrl_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (1'b0),
    .enq_i     (ctrl_enq),
    .data_i    (ctrl_cmd_i),
    .deq_i     (ctrl_deq),
    .data_o    (ctrl_data),
    .full_o    (ctrl_full),
    .empty_o   (ctrl_empty)
  );

  bp_fe_cmd_fifo #(.width_p(fe_cmd_width_p), .els_p(attaboy_els_p)) atb_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (atb_flush),
    .enq_i     (atb_enq),
    .data_i    (attaboy_cmd_i),
    .deq_i     (atb_deq),
    .data_o    (atb_data),
    .full_o    (atb_full),
    .empty_o   (atb_empty)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_r      <= '0;
      hold_r        <= 1'b0;
      sel_attaboy_r <= 1'b0;
    end else begin
      hold_r        <= fe_cmd_v_o & ~fe_cmd_yumi_i;
      sel_attaboy_r <= sel_attaboy;
      if (atb_empty | atb_deq | atb_flush)
        starve_r <= '0;
      else if (ctrl_deq && (starve_r != starve_max))
        starve_r <= starve_r + starve_w'(1);
    end
  end
endmodule
